pc_fetch_unit: RTL and testbench

Program-counter and fetch-control stage that sits directly upstream of the instruction memory. Each clock it holds the current PC, which drives the memory's `next_pc` address input, and samples the returned instruction word. It then computes the following PC from a sequential, branch or jump request. It also detects end-of-program conditions: a run of all-zero words, or a fetch past the last valid ROM address. On either condition it freezes in a HALTED state and reports retired-instruction and halt-cause status.

---
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and fetch control with NOP-run and address-range halt
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          HALT_NOPS = 2,
    parameter logic [31:0] PC_LIMIT  = 32'h0000_00FC
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] instruction_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        halted_o,
    output logic [1:0]  halt_cause_o,
    output logic [31:0] retired_count_o
);

    typedef enum logic {
        RUN,
        HALTED
    } state_e;

    localparam logic [3:0] NOP_LAST    = 4'(HALT_NOPS - 1);
    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_NOP   = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [3:0]  nop_cnt_q, nop_cnt_d;
    logic [1:0]  cause_q, cause_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_target;
    logic [31:0] retired_inc;
    logic        is_nop;
    logic        nop_halt;
    logic        range_halt;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + (branch_offset_i << 2);
    assign jump_target   = {pc_plus4[31:28], jump_index_i, 2'b00};

    always_comb begin
        next_target = pc_plus4;
        if (jump_i) begin
            next_target = jump_target;
        end else if (branch_taken_i) begin
            next_target = branch_target;
        end
    end

    assign is_nop      = (instruction_i == 32'h0000_0000);
    assign nop_halt    = is_nop && (nop_cnt_q == NOP_LAST);
    assign range_halt  = (next_target > PC_LIMIT);
    assign retired_inc = (retired_q == 32'hFFFF_FFFF) ? retired_q : retired_q + 32'd1;

    // NOP halt is checked first so it wins over a simultaneous range halt
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        nop_cnt_d = nop_cnt_q;
        cause_d   = cause_q;
        if ((state_q == RUN) && !stall_i) begin
            nop_cnt_d = is_nop ? nop_cnt_q + 4'd1 : 4'd0;
            if (nop_halt) begin
                state_d = HALTED;
                cause_d = CAUSE_NOP;
            end else if (range_halt) begin
                state_d   = HALTED;
                cause_d   = CAUSE_RANGE;
                retired_d = retired_inc;
            end else begin
                pc_d      = next_target;
                retired_d = retired_inc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
            nop_cnt_q <= 4'd0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            nop_cnt_q <= nop_cnt_d;
            cause_q   <= cause_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_plus4_o      = pc_plus4;
    assign halted_o        = (state_q == HALTED);
    assign halt_cause_o    = cause_q;
    assign retired_count_o = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

    typedef logic [98:0] rec_t;

    localparam logic [31:0] NZ = 32'h2002_0001;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_offset_i = 32'd0;
    logic        jump_i = 1'b0;
    logic [25:0] jump_index_i = 26'd0;
    logic [31:0] instruction_i = NZ;

    logic [31:0] pc_o, pc_plus4_o, retired_count_o;
    logic        halted_o;
    logic [1:0]  halt_cause_o;
    logic [31:0] l_pc_o, l_pc_plus4_o, l_retired_count_o;
    logic        l_halted_o;
    logic [1:0]  l_halt_cause_o;

    int checks = 0;
    int errors = 0;

    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t lim_q[$];

    pc_fetch_unit u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_offset_i(branch_offset_i),
        .jump_i(jump_i), .jump_index_i(jump_index_i), .instruction_i(instruction_i),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .halted_o(halted_o),
        .halt_cause_o(halt_cause_o), .retired_count_o(retired_count_o)
    );

    pc_fetch_unit #(.PC_LIMIT(32'h0000_003C)) u_dut_lim (
        .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_offset_i(branch_offset_i),
        .jump_i(jump_i), .jump_index_i(jump_index_i), .instruction_i(instruction_i),
        .pc_o(l_pc_o), .pc_plus4_o(l_pc_plus4_o), .halted_o(l_halted_o),
        .halt_cause_o(l_halt_cause_o), .retired_count_o(l_retired_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] ret,
                                input logic h, input logic [1:0] cause);
        return {pc, pc + 32'd4, ret, h, cause};
    endfunction

    task automatic step(input logic rst, input logic stl, input logic br,
                        input logic [31:0] off, input logic jmp,
                        input logic [25:0] idx, input logic [31:0] instr);
        reset_i         = rst;
        stall_i         = stl;
        branch_taken_i  = br;
        branch_offset_i = off;
        jump_i          = jmp;
        jump_index_i    = idx;
        instruction_i   = instr;
        @(posedge clk_i);
        #1;
        obs_q.push_back({pc_o, pc_plus4_o, retired_count_o, halted_o, halt_cause_o});
        lim_q.push_back({l_pc_o, l_pc_plus4_o, l_retired_count_o, l_halted_o, l_halt_cause_o});
    endtask

    task automatic test_reset();
        rec_t e, o;
        int n = 0;
        exp_q.push_back(mk(32'h00, 0, 0, 0)); step(1, 0, 0, 0, 0, 0, NZ);
        exp_q.push_back(mk(32'h00, 0, 0, 0)); step(1, 0, 0, 0, 0, 0, NZ);
        exp_q.push_back(mk(32'h04, 1, 0, 0)); step(0, 0, 0, 0, 0, 0, NZ);
        exp_q.push_back(mk(32'h08, 2, 0, 0)); step(0, 0, 0, 0, 0, 0, NZ);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d] got pc=%h ret=%0d halt=%b cause=%b, expected pc=%h ret=%0d halt=%b cause=%b",
                         n, o[98:67], o[34:3], o[2], o[1:0], e[98:67], e[34:3], e[2], e[1:0]);
            end
            n++;
        end
    endtask

    task automatic test_branch_jump();
        rec_t e, o;
        int n = 0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(mk(32'h08 + 32'(4 * i), 32'(2 + i), 0, 0));
            step(0, 0, 0, 0, 0, 0, NZ);
        end
        exp_q.push_back(mk(32'h3C, 7, 0, 0));  step(0, 0, 1, 32'd8, 0, 26'h0, NZ);
        exp_q.push_back(mk(32'h34, 8, 0, 0));  step(0, 0, 0, 0, 1, 26'hD, NZ);
        exp_q.push_back(mk(32'h3C, 9, 0, 0));  step(0, 0, 0, 0, 1, 26'hF, NZ);
        exp_q.push_back(mk(32'h18, 10, 0, 0)); step(0, 0, 0, 0, 1, 26'h6, NZ);
        exp_q.push_back(mk(32'h10, 11, 0, 0)); step(0, 0, 1, 32'd8, 1, 26'h4, NZ);
        exp_q.push_back(mk(32'h04, 12, 0, 0)); step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, NZ);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch_jump[%0d] got pc=%h pc4=%h ret=%0d halt=%b, expected pc=%h pc4=%h ret=%0d halt=%b",
                         n, o[98:67], o[66:35], o[34:3], o[2], e[98:67], e[66:35], e[34:3], e[2]);
            end
            n++;
        end
    endtask

    task automatic test_nop_counter();
        rec_t e, o;
        int n = 0;
        exp_q.push_back(mk(32'h08, 13, 0, 0)); step(0, 0, 0, 0, 0, 0, 32'h0);
        exp_q.push_back(mk(32'h0C, 14, 0, 0)); step(0, 0, 0, 0, 0, 0, NZ);
        exp_q.push_back(mk(32'h10, 15, 0, 0)); step(0, 0, 0, 0, 0, 0, 32'h0);
        exp_q.push_back(mk(32'h10, 15, 1, 1)); step(0, 0, 0, 0, 0, 0, 32'h0);
        exp_q.push_back(mk(32'h00, 0, 0, 0));  step(1, 0, 0, 0, 0, 0, NZ);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL nop_counter[%0d] got pc=%h ret=%0d halt=%b cause=%b, expected pc=%h ret=%0d halt=%b cause=%b",
                         n, o[98:67], o[34:3], o[2], o[1:0], e[98:67], e[34:3], e[2], e[1:0]);
            end
            n++;
        end
    endtask

    task automatic test_nop_halt();
        rec_t e, o;
        int n = 0;
        exp_q.push_back(mk(32'h40, 1, 0, 0)); step(0, 0, 0, 0, 1, 26'h10, NZ);
        exp_q.push_back(mk(32'h44, 2, 0, 0)); step(0, 0, 0, 0, 0, 0, 32'h0);
        exp_q.push_back(mk(32'h44, 2, 1, 1)); step(0, 0, 0, 0, 0, 0, 32'h0);
        exp_q.push_back(mk(32'h44, 2, 1, 1)); step(0, 0, 0, 0, 1, 26'h3, NZ);
        exp_q.push_back(mk(32'h44, 2, 1, 1)); step(0, 0, 1, 32'd4, 0, 0, NZ);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL nop_halt[%0d] got pc=%h ret=%0d halt=%b cause=%b, expected pc=%h ret=%0d halt=%b cause=%b",
                         n, o[98:67], o[34:3], o[2], o[1:0], e[98:67], e[34:3], e[2], e[1:0]);
            end
            n++;
        end
    endtask

    task automatic test_stall_reset();
        rec_t e, o;
        int n = 0;
        exp_q.push_back(mk(32'h00, 0, 0, 0)); step(1, 0, 0, 0, 0, 0, NZ);
        exp_q.push_back(mk(32'h04, 1, 0, 0)); step(0, 0, 0, 0, 0, 0, NZ);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(32'h04, 1, 0, 0));
            step(0, 1, 0, 0, 1, 26'h20, 32'h0);
        end
        exp_q.push_back(mk(32'h08, 2, 0, 0)); step(0, 0, 0, 0, 0, 0, 32'h0);
        exp_q.push_back(mk(32'h08, 2, 1, 1)); step(0, 0, 0, 0, 0, 0, 32'h0);
        exp_q.push_back(mk(32'h00, 0, 0, 0)); step(1, 0, 0, 0, 1, 26'h7, NZ);
        exp_q.push_back(mk(32'h04, 1, 0, 0)); step(0, 0, 0, 0, 0, 0, NZ);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_reset[%0d] got pc=%h ret=%0d halt=%b cause=%b, expected pc=%h ret=%0d halt=%b cause=%b",
                         n, o[98:67], o[34:3], o[2], o[1:0], e[98:67], e[34:3], e[2], e[1:0]);
            end
            n++;
        end
    endtask

    task automatic test_range_halt();
        rec_t e, o;
        int n = 0;
        exp_q.push_back(mk(32'h00, 0, 0, 0)); step(1, 0, 0, 0, 0, 0, NZ);
        exp_q.push_back(mk(32'h00, 1, 0, 0)); step(0, 0, 1, 32'hFFFF_FFFF, 0, 0, NZ);
        exp_q.push_back(mk(32'hFC, 2, 0, 0)); step(0, 0, 0, 0, 1, 26'h3F, NZ);
        exp_q.push_back(mk(32'hFC, 3, 1, 2)); step(0, 0, 0, 0, 0, 0, NZ);
        exp_q.push_back(mk(32'hFC, 3, 1, 2)); step(0, 0, 0, 0, 1, 26'h1, NZ);
        exp_q.push_back(mk(32'h00, 0, 0, 0)); step(1, 0, 0, 0, 0, 0, NZ);
        exp_q.push_back(mk(32'hF8, 1, 0, 0)); step(0, 0, 0, 0, 1, 26'h3E, NZ);
        exp_q.push_back(mk(32'hFC, 2, 0, 0)); step(0, 0, 0, 0, 0, 0, 32'h0);
        exp_q.push_back(mk(32'hFC, 2, 1, 1)); step(0, 0, 0, 0, 0, 0, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL range_halt[%0d] got pc=%h ret=%0d halt=%b cause=%b, expected pc=%h ret=%0d halt=%b cause=%b",
                         n, o[98:67], o[34:3], o[2], o[1:0], e[98:67], e[34:3], e[2], e[1:0]);
            end
            n++;
        end
    endtask

    task automatic test_range_limit();
        rec_t e, o;
        int n = 0;
        lim_q.delete();
        exp_q.push_back(mk(32'h00, 0, 0, 0)); step(1, 0, 0, 0, 0, 0, NZ);
        for (int i = 1; i <= 15; i++) begin
            exp_q.push_back(mk(32'(4 * i), 32'(i), 0, 0));
            step(0, 0, 0, 0, 0, 0, NZ);
        end
        exp_q.push_back(mk(32'h3C, 16, 1, 2)); step(0, 0, 0, 0, 0, 0, NZ);
        exp_q.push_back(mk(32'h3C, 16, 1, 2)); step(0, 0, 0, 0, 1, 26'h2, NZ);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (lim_q.size() > 0) ? lim_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL range_limit[%0d] got pc=%h ret=%0d halt=%b cause=%b, expected pc=%h ret=%0d halt=%b cause=%b",
                         n, o[98:67], o[34:3], o[2], o[1:0], e[98:67], e[34:3], e[2], e[1:0]);
            end
            n++;
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_branch_jump();
        test_nop_counter();
        test_nop_halt();
        test_stall_reset();
        test_range_halt();
        test_range_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
